// File: rtl/sampled_value_monitor.sv
// Multi-channel synthesizable $changed/$stable/$rose/$fell/$past monitor with
// registered flags and saturating per-channel changed/stable event counters.
module sampled_value_monitor #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr_counts,
    input  logic [CHANNELS*WIDTH-1:0]   data_in,
    output logic [CHANNELS-1:0]         changed,
    output logic [CHANNELS-1:0]         stable,
    output logic [CHANNELS-1:0]         rose,
    output logic [CHANNELS-1:0]         fell,
    output logic                        sample_valid,
    output logic                        past_valid,
    output logic [CHANNELS*WIDTH-1:0]   past_out,
    output logic [CHANNELS*CNT_W-1:0]   changed_count,
    output logic [CHANNELS*CNT_W-1:0]   stable_count
);

    localparam int unsigned SC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    r_hist [CHANNELS][DEPTH];
    logic [CNT_W-1:0]    r_chg_cnt [CHANNELS];
    logic [CNT_W-1:0]    r_stb_cnt [CHANNELS];
    logic [CHANNELS-1:0] r_changed;
    logic [CHANNELS-1:0] r_stable;
    logic [CHANNELS-1:0] r_rose;
    logic [CHANNELS-1:0] r_fell;
    logic                r_sample_valid;
    logic                r_past_valid;
    logic [SC_W-1:0]     r_samp_cnt;

    logic [CHANNELS-1:0] w_chg;
    logic [CHANNELS-1:0] w_rose;
    logic [CHANNELS-1:0] w_fell;

    // New comparison results against the previous sample (hist[0])
    always_comb begin
        w_chg  = '0;
        w_rose = '0;
        w_fell = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_chg[c]  = (data_in[c*WIDTH +: WIDTH] != r_hist[c][0]);
            w_rose[c] = !r_hist[c][0][0] &&  data_in[c*WIDTH];
            w_fell[c] =  r_hist[c][0][0] && !data_in[c*WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                for (int k = 0; k < int'(DEPTH); k++) begin
                    r_hist[c][k] <= '0;
                end
                r_chg_cnt[c] <= '0;
                r_stb_cnt[c] <= '0;
            end
            r_changed      <= '0;
            r_stable       <= '0;
            r_rose         <= '0;
            r_fell         <= '0;
            r_sample_valid <= 1'b0;
            r_past_valid   <= 1'b0;
            r_samp_cnt     <= '0;
        end else begin
            r_sample_valid <= en;
            if (en) begin
                r_changed <= w_chg;
                r_stable  <= ~w_chg;
                r_rose    <= w_rose;
                r_fell    <= w_fell;
                for (int c = 0; c < int'(CHANNELS); c++) begin
                    r_hist[c][0] <= data_in[c*WIDTH +: WIDTH];
                    for (int k = 1; k < int'(DEPTH); k++) begin
                        r_hist[c][k] <= r_hist[c][k-1];
                    end
                end
                if (r_samp_cnt != SC_W'(DEPTH)) begin
                    r_samp_cnt <= r_samp_cnt + SC_W'(1);
                end
                if (r_samp_cnt >= SC_W'(DEPTH - 1)) begin
                    r_past_valid <= 1'b1;
                end
            end
            // Clear wins over any increment on the same edge
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (clr_counts) begin
                    r_chg_cnt[c] <= '0;
                    r_stb_cnt[c] <= '0;
                end else if (en) begin
                    if (w_chg[c] && (r_chg_cnt[c] != {CNT_W{1'b1}})) begin
                        r_chg_cnt[c] <= r_chg_cnt[c] + CNT_W'(1);
                    end
                    if (!w_chg[c] && (r_stb_cnt[c] != {CNT_W{1'b1}})) begin
                        r_stb_cnt[c] <= r_stb_cnt[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign past_out[c*WIDTH +: WIDTH]      = r_hist[c][DEPTH-1];
        assign changed_count[c*CNT_W +: CNT_W] = r_chg_cnt[c];
        assign stable_count[c*CNT_W +: CNT_W]  = r_stb_cnt[c];
    end

    assign changed      = r_changed;
    assign stable       = r_stable;
    assign rose         = r_rose;
    assign fell         = r_fell;
    assign sample_valid = r_sample_valid;
    assign past_valid   = r_past_valid;

endmodule

// File: tb/tb_sampled_value_monitor.sv
// Directed self-checking bench for sampled_value_monitor (4 channels, 8-bit, DEPTH=2, CNT_W=4).
module tb_sampled_value_monitor;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned CNT_W    = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic                      clr_counts;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       changed, stable, rose, fell;
    logic                      sample_valid, past_valid;
    logic [CHANNELS*WIDTH-1:0] past_out;
    logic [CHANNELS*CNT_W-1:0] changed_count, stable_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sampled_value_monitor #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr_counts(clr_counts), .data_in(data_in),
        .changed(changed), .stable(stable), .rose(rose), .fell(fell),
        .sample_valid(sample_valid), .past_valid(past_valid), .past_out(past_out),
        .changed_count(changed_count), .stable_count(stable_count)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one clock with the given controls, then settle past the edge
    task automatic cycle(input logic r, input logic e, input logic clr, input logic [31:0] d);
        @(negedge clk);
        rst        = r;
        en         = e;
        clr_counts = clr;
        data_in    = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] ccnt(input int c);
        logic [CHANNELS*CNT_W-1:0] v;
        v = changed_count;
        return v[c*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] scnt(input int c);
        logic [CHANNELS*CNT_W-1:0] v;
        v = stable_count;
        return v[c*CNT_W +: CNT_W];
    endfunction

    function automatic logic [WIDTH-1:0] pout(input int c);
        logic [CHANNELS*WIDTH-1:0] v;
        v = past_out;
        return v[c*WIDTH +: WIDTH];
    endfunction

    logic [7:0] seq2 [5]  = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h01};
    logic       rose2 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       fell2 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst = 1'b1; en = 1'b0; clr_counts = 1'b0; data_in = '0;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_changed", 64'(changed), 64'h0);
        check("rst_stable", 64'(stable), 64'h0);
        check("rst_rose_fell", 64'({rose, fell}), 64'h0);
        check("rst_valids", 64'({sample_valid, past_valid}), 64'h0);
        check("rst_counts", 64'({changed_count, stable_count}), 64'h0);
        check("rst_past_out", 64'(past_out), 64'h0);

        // Three stable zero samples
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_past_valid", 64'(past_valid), 64'h0);
        check("s1_sample_valid", 64'(sample_valid), 64'h1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s2_past_valid", 64'(past_valid), 64'h1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("s3_stable0", 64'(stable[0]), 64'h1);
        check("s3_changed0", 64'(changed[0]), 64'h0);
        check("s3_stable_cnt0", 64'(scnt(0)), 64'd3);
        check("s3_changed_cnt0", 64'(ccnt(0)), 64'd0);

        // Rose/fell sequence on ch0 LSB
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'(seq2[i]));
            check($sformatf("seq_rose_%0d", i + 1), 64'(rose[0]), 64'(rose2[i]));
            check($sformatf("seq_fell_%0d", i + 1), 64'(fell[0]), 64'(fell2[i]));
        end
        check("seq_changed_cnt0", 64'(ccnt(0)), 64'd3);
        check("seq_stable_cnt0", 64'(scnt(0)), 64'd2);
        check("seq_past_out0", 64'(pout(0)), 64'h01);

        // en=0: everything frozen while data toggles
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, (i % 2 == 0) ? 32'hFFFF_FFFE : 32'h5555_5555);
            check($sformatf("hold_sample_valid_%0d", i), 64'(sample_valid), 64'h0);
        end
        check("hold_flags0", 64'({changed[0], stable[0], rose[0], fell[0]}), 64'b0100);
        check("hold_counts0", 64'({ccnt(0), scnt(0)}), 64'h32);
        check("hold_past_out0", 64'(pout(0)), 64'h01);
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_0001);
        check("hold_hist_kept", 64'(stable[0]), 64'h1);

        // Saturation, then clear together with a stable sample
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("sat_stable_cnt0", 64'(scnt(0)), 64'd15);
        check("sat_changed_cnt0", 64'(ccnt(0)), 64'd0);
        cycle(1'b0, 1'b1, 1'b1, 32'h0);
        check("clr_stable_cnt0", 64'(scnt(0)), 64'd0);
        check("clr_stable0", 64'(stable[0]), 64'h1);
        check("clr_past_valid", 64'(past_valid), 64'h1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("post_clr_cnt0", 64'(scnt(0)), 64'd1);

        // Channel independence: ch1 constant 0xAA, ch2 toggles 0x55/0xAA
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d2;
            d2 = (i % 2 == 0) ? 8'h55 : 8'hAA;
            cycle(1'b0, 1'b1, 1'b0, {8'h00, d2, 8'hAA, 8'h00});
            check($sformatf("ind_rose2_%0d", i + 1), 64'(rose[2]), 64'(i % 2 == 0));
            check($sformatf("ind_fell2_%0d", i + 1), 64'(fell[2]), 64'(i % 2 == 1));
            check($sformatf("ind_ch1_flags_%0d", i + 1), 64'({changed[1], rose[1], fell[1]}),
                  (i == 0) ? 64'b100 : 64'b000);
        end
        check("ind_stable_cnt1", 64'(scnt(1)), 64'd5);
        check("ind_changed_cnt1", 64'(ccnt(1)), 64'd1);
        check("ind_changed_cnt2", 64'(ccnt(2)), 64'd6);
        check("ind_stable_cnt0", 64'(scnt(0)), 64'd6);

        // Reset mid-operation with en=1
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_0013);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_00FF);
        check("mid_rst_flags", 64'({changed, stable, rose, fell}), 64'h0);
        check("mid_rst_misc", 64'({sample_valid, past_valid, past_out}), 64'h0);
        check("mid_rst_counts", 64'({changed_count, stable_count}), 64'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_00FF);
        check("mid_changed0", 64'(changed[0]), 64'h1);
        check("mid_rose0", 64'(rose[0]), 64'h1);
        check("mid_changed_cnt0", 64'(ccnt(0)), 64'd1);
        check("mid_past_valid", 64'(past_valid), 64'h0);
        check("mid_past_out0", 64'(pout(0)), 64'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
